// File: rtl/max_ci_pkg.sv
// Shared types and helpers for the max-search custom instruction.
// Opcode decode, FSM state encoding and the sample comparison rule.
package max_ci_pkg;

    typedef enum logic [2:0] {
        OP_CLEAR    = 3'd0,
        OP_PUSH     = 3'd1,
        OP_SCAN     = 3'd2,
        OP_READ_IDX = 3'd3,
        OP_COUNT    = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FINISH
    } state_e;

    // Opcodes 5..7 complete normally with result 0 and touch no state.
    function automatic logic op_is_legal(input logic [2:0] n);
        return n <= 3'd4;
    endfunction

    function automatic logic sample_gt(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic        signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/max_ci_controller_scan.sv
// Running max / argmax tracker fed one buffer entry per step.
// Only a strictly greater sample replaces the max, so ties keep the oldest.
module max_scan_unit
    import max_ci_pkg::*;
#(
    parameter int unsigned AGE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             valid,
    input  logic [31:0]      sample,
    input  logic [AGE_W-1:0] age,
    input  logic             signed_mode,
    output logic [31:0]      max,
    output logic [AGE_W-1:0] max_age
);

    logic have;

    always_ff @(posedge clk) begin
        if (!reset) begin
            max     <= '0;
            max_age <= '0;
            have    <= 1'b0;
        end else if (init) begin
            max     <= '0;
            max_age <= '0;
            have    <= 1'b0;
        end else if (valid && (!have || sample_gt(sample, max, signed_mode))) begin
            max     <= sample;
            max_age <= age;
            have    <= 1'b1;
        end
    end

endmodule

// File: rtl/max_ci_controller.sv
// Nios II variable multi-cycle custom instruction: circular sample buffer
// plus a sequenced max search returning value, position and count.
module max_ci_controller
    import max_ci_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [2:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [IDX_W:0]   count_q, count_inc;
    logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q, age_q, last_idx_q, oldest;
    logic [31:0]      mem [DEPTH];
    logic [31:0]      pend_q;
    logic             scan_flag_q, signed_q;
    logic             accept, push_fire, scan_start, scan_step, finish, scan_last;
    logic             op_legal;
    logic [31:0]      scan_max;
    logic [IDX_W-1:0] scan_max_age;
    logic             unused_datab;

    assign unused_datab = ^datab[31:1];
    assign op_legal     = op_is_legal(n);
    assign count_inc    = (count_q == (IDX_W+1)'(DEPTH)) ? count_q : count_q + 1'b1;
    assign oldest       = wr_ptr_q - count_q[IDX_W-1:0];
    assign scan_last    = ({1'b0, age_q} == count_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        push_fire  = 1'b0;
        scan_start = 1'b0;
        scan_step  = 1'b0;
        finish     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    push_fire = (n == OP_PUSH);
                    if (n == OP_SCAN && count_q != '0) begin
                        scan_start = 1'b1;
                        state_d    = ST_SCAN;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_SCAN: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer contents survive reset; only the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (reset && clk_en && push_fire) begin
            mem[wr_ptr_q] <= dataa;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            age_q       <= '0;
            last_idx_q  <= '0;
            pend_q      <= '0;
            scan_flag_q <= 1'b0;
            signed_q    <= 1'b0;
            result      <= '0;
            done        <= 1'b0;
        end else if (clk_en) begin
            done <= finish;
            if (finish) begin
                result <= scan_flag_q ? scan_max : pend_q;
                if (scan_flag_q) begin
                    last_idx_q <= scan_max_age;
                end
            end
            if (accept) begin
                pend_q      <= '0;
                scan_flag_q <= 1'b0;
                if (op_legal) begin
                    case (n)
                        OP_CLEAR: begin
                            count_q    <= '0;
                            wr_ptr_q   <= '0;
                            last_idx_q <= '0;
                        end
                        OP_PUSH: begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            count_q  <= count_inc;
                            pend_q   <= 32'(count_inc);
                        end
                        OP_SCAN: begin
                            if (scan_start) begin
                                scan_flag_q <= 1'b1;
                                rd_ptr_q    <= oldest;
                                age_q       <= '0;
                                signed_q    <= datab[0];
                            end else begin
                                last_idx_q <= '0;
                            end
                        end
                        OP_READ_IDX: pend_q <= 32'(last_idx_q);
                        OP_COUNT:    pend_q <= 32'(count_q);
                        default: ;
                    endcase
                end
            end
            if (scan_step) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                age_q    <= age_q + 1'b1;
            end
        end
    end

    max_scan_unit #(
        .AGE_W(IDX_W)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .init        (clk_en && scan_start),
        .valid       (clk_en && scan_step),
        .sample      (mem[rd_ptr_q]),
        .age         (age_q),
        .signed_mode (signed_q),
        .max         (scan_max),
        .max_age     (scan_max_age)
    );

endmodule

// File: tb/tb_max_ci_controller.sv
// Scoreboard bench for max_ci_controller: a queue-based reference model
// predicts result and latency; a negedge monitor checks each done pulse.
module tb_max_ci_controller;
    import max_ci_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  n = '0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic        done;
    logic [31:0] result;

    max_ci_controller #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mq[$];
    int          last_idx = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          en_last = 1'b0;

    always @(posedge clk) begin
        cyc++;
        en_last = clk_en;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && done && en_last) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done result=%h cycle=%0d", result, cyc);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (result !== e.res) begin
                    failures++;
                    $display("FAIL result op=%0d got=%h expected=%h", e.op, result, e.res);
                end
                if (cyc - e.t0 != e.lat) begin
                    failures++;
                    $display("FAIL latency op=%0d got=%0d expected=%0d", e.op, cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        int best;
        lat = 1;
        r   = '0;
        case (op)
            3'd0: begin
                mq.delete();
                last_idx = 0;
            end
            3'd1: begin
                mq.push_back(a);
                if (mq.size() > DEPTH) void'(mq.pop_front());
                r = 32'(mq.size());
            end
            3'd2: begin
                last_idx = 0;
                if (mq.size() > 0) begin
                    best = 0;
                    for (int i = 1; i < mq.size(); i++) begin
                        if (b[0] ? ($signed(mq[i]) > $signed(mq[best])) : (mq[i] > mq[best]))
                            best = i;
                    end
                    r        = mq[best];
                    last_idx = best;
                    lat      = mq.size() + 1;
                end
            end
            3'd3: r = 32'(last_idx);
            3'd4: r = 32'(mq.size());
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, input int extra);
        logic [31:0] r;
        int          lat;
        exp_t        e;
        @(negedge clk);
        model(op, a, b, r, lat);
        n     = op;
        dataa = a;
        datab = b;
        start = 1'b1;
        if (expect_done) begin
            e.res = r;
            e.lat = lat + extra;
            e.t0  = cyc + 1;
            e.op  = op;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic op_do(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b1, 0);
        wait_drain();
    endtask

    initial begin
        int r;
        logic [31:0] v;

        repeat (3) begin
            @(negedge clk);
            chk("reset_done", {31'b0, done}, 32'd0);
            chk("reset_result", result, 32'd0);
        end
        reset = 1'b1;

        op_do(OP_COUNT, 0, 0);
        op_do(OP_PUSH, 5, 0);
        op_do(OP_PUSH, 9, 0);
        op_do(OP_PUSH, 3, 0);
        op_do(OP_SCAN, 0, 0);
        op_do(OP_READ_IDX, 0, 0);

        op_do(OP_CLEAR, 0, 0);
        op_do(OP_PUSH, 32'hFFFF_FFFF, 0);
        op_do(OP_PUSH, 32'h0000_0001, 0);
        op_do(OP_SCAN, 0, 1);
        op_do(OP_SCAN, 0, 0);

        op_do(OP_CLEAR, 0, 0);
        repeat (3) op_do(OP_PUSH, 7, 0);
        op_do(OP_SCAN, 0, 0);
        op_do(OP_READ_IDX, 0, 0);
        op_do(OP_CLEAR, 0, 0);
        op_do(OP_SCAN, 0, 0);
        op_do(OP_READ_IDX, 0, 0);

        for (int i = 1; i <= 20; i++) op_do(OP_PUSH, (i == 4) ? 32'd100 : 32'(i), 0);
        op_do(OP_COUNT, 0, 0);
        op_do(OP_SCAN, 0, 0);
        op_do(OP_READ_IDX, 0, 0);
        op_do(3'd6, 32'h1234, 0);
        op_do(OP_COUNT, 0, 0);

        // Stall the clock qualifier for three cycles in the middle of a scan.
        op_do(OP_CLEAR, 0, 0);
        repeat (8) op_do(OP_PUSH, $urandom, 0);
        issue(OP_SCAN, 0, 1, 1'b1, 3);
        repeat (2) @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        wait_drain();
        op_do(OP_READ_IDX, 0, 0);

        // Reset in the middle of a scan must abort it silently.
        repeat (5) op_do(OP_PUSH, $urandom_range(0, 50), 0);
        op_do(OP_SCAN, 0, 0);
        issue(OP_SCAN, 0, 0, 1'b0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midscan_reset_done", {31'b0, done}, 32'd0);
        chk("midscan_reset_result", result, 32'd0);
        reset = 1'b1;
        mq.delete();
        last_idx = 0;
        repeat (30) @(negedge clk);
        op_do(OP_READ_IDX, 0, 0);
        op_do(OP_COUNT, 0, 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            v = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 7));
            if (r < 45)      op_do(OP_PUSH, v, 0);
            else if (r < 60) op_do(OP_SCAN, 0, $urandom);
            else if (r < 70) op_do(OP_READ_IDX, 0, 0);
            else if (r < 80) op_do(OP_COUNT, 0, 0);
            else if (r < 84) op_do(OP_CLEAR, 0, 0);
            else if (r < 90) op_do(3'($urandom_range(5, 7)), v, 0);
            else             op_do(OP_PUSH, v, 0);
        end
        op_do(OP_SCAN, 0, 1);
        op_do(OP_READ_IDX, 0, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_ci_controller.md
# max_ci_controller

Variable multi-cycle Nios II custom instruction that owns a small circular sample buffer and sequences a max-search datapath over it. Software pushes 32-bit samples one instruction at a time, then issues a SCAN that walks the buffer oldest-to-newest and returns the maximum. Follow-up instructions read the max's position and the sample count. The block sits on the CPU's custom-instruction port and gives the max-finding unit its operand sequencing, buffering and done handshake.

## Interface
- DEPTH, 16, buffer entries; power of two, 2..256
- IDX_W, clog2(DEPTH), derived localparam; not overridable
- clk  in  1  CPU master clock
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- clk_en  in  1  clock qualifier; when 0 all state, counters and outputs hold
- start  in  1  instruction issue; sampled only when clk_en=1
- n  in  3  opcode: 0 CLEAR, 1 PUSH, 2 SCAN, 3 READ_IDX, 4 COUNT, 5-7 illegal
- dataa  in  32  PUSH sample value
- datab  in  32  SCAN mode: bit0=1 signed compare, 0 unsigned; other bits ignored
- done  out  1  one-cycle completion pulse
- result  out  32  instruction result; valid when done=1, held until next done

## Operation
- FSM states: IDLE, SCAN, FINISH.
- IDLE + start: CLEAR/PUSH/READ_IDX/COUNT/illegal go to FINISH; SCAN goes to SCAN if count>0, else FINISH.
- CLEAR: count←0, wr_ptr←0, last_idx←0. result=0.
- PUSH: buf[wr_ptr]←dataa, wr_ptr←wr_ptr+1 mod DEPTH, count←min(count+1, DEPTH). When full, the oldest entry is overwritten. result=count after the push.
- SCAN: read pointer starts at oldest=(wr_ptr−count) mod DEPTH and advances one entry per enabled cycle for count entries.
  - Comparator replaces the running max only on strictly greater, so on ties the oldest entry wins.
  - On completion, result=max; last_idx←age offset of the max (0=oldest).
  - Empty buffer: result=0, last_idx←0.
- READ_IDX: result=zero-extended last_idx.
- COUNT: result=zero-extended count (0..DEPTH).
- Illegal opcode: result=0; no state change.
- FINISH: done=1 for one cycle, then return to IDLE.
- start outside IDLE is ignored.

## Timing
- Reset values: done=0, result=0, state IDLE, count=0, wr_ptr=0, last_idx=0. Buffer contents are not cleared.
- Latency is counted in clk_en=1 cycles from the start edge to the done edge:
  - non-SCAN ops: 1
  - SCAN: count+1 (1 when empty)
- clk_en=0 in any state freezes everything; a done pending in FINISH is emitted only on the next enabled edge.
- Reset asserted mid-SCAN aborts the scan: no done, and last_idx returns to 0.
- A PUSH cannot overlap a SCAN, because start is ignored while busy.

## Structure
- Package max_ci_pkg holds:
  - op_e enum (CLEAR..COUNT) and the illegal-opcode rule
  - state_e enum (IDLE, SCAN, FINISH)
- Sub-module max_scan_unit holds the running max/argmax registers.
  - Inputs: init, valid, sample, age, signed_mode.
  - Outputs: max, max_age.
  - Strictly-greater update rule.
- The controller owns the buffer, pointers, FSM and result mux.

## Test plan
- Reset, then COUNT → done after 1 cycle, result=0. Check done=0 and result=0 while reset is low.
- PUSH 5, 9, 3, then SCAN unsigned → done 4 cycles after start, result=9. READ_IDX → 1.
- PUSH 0xFFFFFFFF, then 0x00000001. SCAN with datab=1 → 0x00000001; SCAN with datab=0 → 0xFFFFFFFF.
- Ties: PUSH 7, 7, 7, then SCAN → result 7, READ_IDX → 0. CLEAR then SCAN → done after 1 cycle, result=0.
- Overflow with DEPTH=16: PUSH values 1..20, then COUNT=16. SCAN → 20 with latency 17, READ_IDX → 15. 100 may be the 4th push, but it is overwritten before the scan.
- clk_en held 0 for 3 cycles mid-SCAN → done is delayed by exactly 3 cycles. Reset pulsed mid-SCAN → no done, and READ_IDX afterwards returns 0.
